// File: rtl/game_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// game_seq_ctrl_pkg
// Shared types and helpers for the game sequencer.
//   - state_e   : sequencer states (TITLE, REVEAL, PLAY, HOLD)
//   - colour_e  : paint colour codes used when describing a target's paint
//   - N_TARGETS : total targets (14 blocks + 6 rects), TGT_IDX_W index width
//   - hit_ok()  : a hit counts only when valid, in range and on a live target
//   - popcount(): number of set bits in a target vector (score counters)
// No ports (package).
// -----------------------------------------------------------------------------
package game_seq_ctrl_pkg;

    localparam int N_TARGETS = 20;
    localparam int TGT_IDX_W = 5;
    localparam int FCNT_W    = 8;

    typedef enum logic [1:0] {
        TITLE  = 2'd0,
        REVEAL = 2'd1,
        PLAY   = 2'd2,
        HOLD   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        COL_NONE   = 2'b00,
        COL_BLUE   = 2'b01,
        COL_ORANGE = 2'b10
    } colour_e;

    // A hit is usable only if it is valid, names an existing target and that
    // target has been revealed. Shifting keeps out-of-range indices harmless.
    function automatic logic hit_ok(input logic                  valid,
                                    input logic [TGT_IDX_W-1:0]  idx,
                                    input logic [N_TARGETS-1:0]  ready);
        logic [N_TARGETS-1:0] shifted;
        shifted = ready >> idx;
        return valid && (idx < TGT_IDX_W'(N_TARGETS)) && shifted[0];
    endfunction

    function automatic logic [TGT_IDX_W-1:0] popcount(input logic [N_TARGETS-1:0] v);
        logic [TGT_IDX_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            n = n + TGT_IDX_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/game_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_seq_ctrl_if
// Ball-hit bus from the collision logic into the game sequencer.
//   blue_hit_valid   : blue ball hit a target this cycle
//   blue_hit_idx     : target index of the blue hit (0..19 meaningful)
//   orange_hit_valid : orange ball hit a target this cycle
//   orange_hit_idx   : target index of the orange hit
// Modports: master (collision logic drives), slave (sequencer receives).
// -----------------------------------------------------------------------------
interface game_seq_ctrl_if;
    import game_seq_ctrl_pkg::*;

    logic                 blue_hit_valid;
    logic [TGT_IDX_W-1:0] blue_hit_idx;
    logic                 orange_hit_valid;
    logic [TGT_IDX_W-1:0] orange_hit_idx;

    modport master (
        output blue_hit_valid, blue_hit_idx,
        output orange_hit_valid, orange_hit_idx
    );

    modport slave (
        input blue_hit_valid, blue_hit_idx,
        input orange_hit_valid, orange_hit_idx
    );

endinterface

// File: rtl/game_seq_ctrl_frame_tick_sync.sv
// -----------------------------------------------------------------------------
// game_seq_ctrl_frame_tick_sync
// Brings the vsync-rate frame_clk into the Clk domain and turns each rising
// edge into a single-cycle frame_tick, three Clk edges after the rise.
// Ports:
//   Clk        in  system clock
//   Reset      in  asynchronous, active-high reset
//   frame_clk  in  frame pulse, asynchronous to Clk
//   frame_tick out 1-Clk pulse per frame_clk rising edge (registered)
// -----------------------------------------------------------------------------
module game_seq_ctrl_frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    // [0] first sync stage, [1] second sync stage, [2] previous synced value
    logic [2:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, like real hardware.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q     <= '0;
            frame_tick <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], frame_clk};
            frame_tick <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/game_seq_ctrl.sv
// -----------------------------------------------------------------------------
// game_seq_ctrl
// Game sequencer feeding color_mapper: title / press-start screen, level
// banners, staggered target reveal and per-target paint state from ball hits.
// All outputs are registered in the Clk domain.
// Ports:
//   Clk, Reset                  clock, asynchronous active-high reset
//   frame_clk                   vsync-rate pulse (synchronised internally)
//   start_key                   debounced start key level
//   hit (game_seq_ctrl_if.slave) blue/orange hit valid + index
//   title, pstart               title screen / blinking press-start enable
//   level_one, level_two        level banner enables
//   block_ready[0:13]           targets 0..13 visible and live
//   rect_ready[0:5]             targets 14..19 visible and live
//   blue_paint, orange_paint    per-target paint state [0:19]
//   blue_score, orange_score    painted-target counts
// Configuration: define SCORE_EN to build the score counters; otherwise the
// score ports are tied to zero.
// -----------------------------------------------------------------------------
module game_seq_ctrl
    import game_seq_ctrl_pkg::*;
#(
    parameter int                   N_BLOCK      = 14,
    parameter int                   N_RECT       = 6,
    parameter int                   BLINK_FRAMES = 30,
    parameter int                   HOLD_FRAMES  = 120,
    parameter logic [N_TARGETS-1:0] LVL1_MASK    = 20'h1C07F,
    parameter logic [N_TARGETS-1:0] LVL2_MASK    = 20'hFFFFF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic                 start_key,
    game_seq_ctrl_if.slave       hit,
    output logic                 title,
    output logic                 pstart,
    output logic                 level_one,
    output logic                 level_two,
    output logic [0:N_BLOCK-1]   block_ready,
    output logic [0:N_RECT-1]    rect_ready,
    output logic [0:N_TARGETS-1] blue_paint,
    output logic [0:N_TARGETS-1] orange_paint,
    output logic [TGT_IDX_W-1:0] blue_score,
    output logic [TGT_IDX_W-1:0] orange_score
);

    localparam logic [N_TARGETS-1:0] ONE_HOT0 = N_TARGETS'(1);
    localparam logic [TGT_IDX_W-1:0] LAST_IDX = TGT_IDX_W'(N_TARGETS - 1);

    logic frame_tick;
    logic start_q, start_edge;

    state_e               state_q, state_d;
    logic                 lvl_q, lvl_d;           // 0 = level one, 1 = level two
    logic [FCNT_W-1:0]    fcnt_q, fcnt_d, fcnt_inc;
    logic [TGT_IDX_W-1:0] ridx_q, ridx_d;
    logic                 blink_q, blink_d;       // press-start phase while in TITLE
    logic [N_TARGETS-1:0] ready_q, ready_d;       // bit i = target i
    logic [N_TARGETS-1:0] bpaint_q, bpaint_d;
    logic [N_TARGETS-1:0] opaint_q, opaint_d;
    logic                 title_d, pstart_d, level_one_d, level_two_d;

    logic [N_TARGETS-1:0] level_mask, reveal_sel, blue_sel, orange_sel;
    logic                 blue_ok, orange_ok, same_target, all_painted;
    logic                 go_title, enter_reveal;

    game_seq_ctrl_frame_tick_sync u_frame_tick_sync (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            start_q    <= 1'b0;
            start_edge <= 1'b0;
        end else begin
            start_q    <= start_key;
            start_edge <= start_key & ~start_q;
        end
    end

    // Hit qualification and level bookkeeping.
    assign level_mask  = lvl_q ? LVL2_MASK : LVL1_MASK;
    assign reveal_sel  = ONE_HOT0 << ridx_q;
    assign blue_sel    = ONE_HOT0 << hit.blue_hit_idx;
    assign orange_sel  = ONE_HOT0 << hit.orange_hit_idx;
    assign blue_ok     = hit_ok(hit.blue_hit_valid, hit.blue_hit_idx, ready_q);
    assign orange_ok   = hit_ok(hit.orange_hit_valid, hit.orange_hit_idx, ready_q);
    // Simultaneous hits on one target cancel rather than racing for the colour.
    assign same_target = hit.blue_hit_valid && hit.orange_hit_valid &&
                         (hit.blue_hit_idx == hit.orange_hit_idx);
    // Uses registered paint, so completion is seen one Clk after the last paint.
    assign all_painted = (((bpaint_q | opaint_q) & ready_q) == ready_q);
    assign fcnt_inc    = (fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        lvl_d        = lvl_q;
        fcnt_d       = fcnt_q;
        ridx_d       = ridx_q;
        blink_d      = blink_q;
        ready_d      = ready_q;
        bpaint_d     = bpaint_q;
        opaint_d     = opaint_q;
        go_title     = 1'b0;
        enter_reveal = 1'b0;

        case (state_q)
            TITLE: begin
                // start_edge wins over a coincident frame_tick.
                if (start_edge) begin
                    enter_reveal = 1'b1;
                    lvl_d        = 1'b0;
                end else if (frame_tick) begin
                    if (fcnt_inc == FCNT_W'(BLINK_FRAMES)) begin
                        blink_d = ~blink_q;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_inc;
                    end
                end
            end

            REVEAL: begin
                if (frame_tick) begin
                    ready_d = ready_q | (level_mask & reveal_sel);
                    if (ridx_q == LAST_IDX) begin
                        state_d = PLAY;
                    end else begin
                        ridx_d = ridx_q + 1'b1;
                    end
                end
            end

            PLAY: begin
                if (start_edge) begin
                    go_title = 1'b1;
                end else if (all_painted) begin
                    state_d = HOLD;
                    fcnt_d  = '0;
                end else if (!same_target) begin
                    if (blue_ok) begin
                        bpaint_d = bpaint_d | blue_sel;
                        opaint_d = opaint_d & ~blue_sel;
                    end
                    if (orange_ok) begin
                        opaint_d = opaint_d | orange_sel;
                        bpaint_d = bpaint_d & ~orange_sel;
                    end
                end
            end

            HOLD: begin
                if (frame_tick) begin
                    if (fcnt_inc == FCNT_W'(HOLD_FRAMES)) begin
                        if (!lvl_q) begin
                            enter_reveal = 1'b1;
                            lvl_d        = 1'b1;
                        end else begin
                            go_title = 1'b1;
                        end
                    end else begin
                        fcnt_d = fcnt_inc;
                    end
                end
            end

            default: go_title = 1'b1;
        endcase

        if (enter_reveal) begin
            state_d  = REVEAL;
            ridx_d   = '0;
            fcnt_d   = '0;
            ready_d  = '0;
            bpaint_d = '0;
            opaint_d = '0;
        end

        if (go_title) begin
            state_d  = TITLE;
            fcnt_d   = '0;
            blink_d  = 1'b1;
            ready_d  = '0;
            bpaint_d = '0;
            opaint_d = '0;
        end

        title_d     = (state_d == TITLE);
        pstart_d    = title_d & blink_d;
        level_one_d = !title_d && !lvl_d;
        level_two_d = !title_d && lvl_d;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= TITLE;
            lvl_q     <= 1'b0;
            fcnt_q    <= '0;
            ridx_q    <= '0;
            blink_q   <= 1'b1;
            ready_q   <= '0;
            bpaint_q  <= '0;
            opaint_q  <= '0;
            title     <= 1'b1;
            pstart    <= 1'b1;
            level_one <= 1'b0;
            level_two <= 1'b0;
        end else begin
            state_q   <= state_d;
            lvl_q     <= lvl_d;
            fcnt_q    <= fcnt_d;
            ridx_q    <= ridx_d;
            blink_q   <= blink_d;
            ready_q   <= ready_d;
            bpaint_q  <= bpaint_d;
            opaint_q  <= opaint_d;
            title     <= title_d;
            pstart    <= pstart_d;
            level_one <= level_one_d;
            level_two <= level_two_d;
        end
    end

    // Ascending output ranges: element i of each port is target i (blocks),
    // or target N_BLOCK+i for the rectangles.
    always_comb begin
        for (int i = 0; i < N_BLOCK; i++) begin
            block_ready[i] = ready_q[i];
        end
        for (int i = 0; i < N_RECT; i++) begin
            rect_ready[i] = ready_q[N_BLOCK + i];
        end
        for (int i = 0; i < N_TARGETS; i++) begin
            blue_paint[i]   = bpaint_q[i];
            orange_paint[i] = opaint_q[i];
        end
    end

`ifdef SCORE_EN
    // Scores follow the registered paint vectors one Clk later.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blue_score   <= '0;
            orange_score <= '0;
        end else begin
            blue_score   <= popcount(bpaint_q);
            orange_score <= popcount(opaint_q);
        end
    end
`else
    assign blue_score   = '0;
    assign orange_score = '0;
`endif

endmodule

// File: tb/tb_game_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_seq_ctrl
// Self-checking bench for game_seq_ctrl. A mode-level reference model (tick
// counts per mode, per-target arrays) predicts every output after each
// stimulus action; random hits exercise the paint rules.
// -----------------------------------------------------------------------------
module tb_game_seq_ctrl;
    import game_seq_ctrl_pkg::*;

    localparam int          BLINK  = 30;
    localparam int          HOLD_N = 120;
    localparam logic [19:0] MASK1  = 20'h1C07F;
    localparam logic [19:0] MASK2  = 20'hFFFFF;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        start_key;
    logic        title, pstart, level_one, level_two;
    logic [0:13] block_ready;
    logic [0:5]  rect_ready;
    logic [0:19] blue_paint, orange_paint;
    logic [4:0]  blue_score, orange_score;

    game_seq_ctrl_if hit_if ();

    game_seq_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .start_key    (start_key),
        .hit          (hit_if),
        .title        (title),
        .pstart       (pstart),
        .level_one    (level_one),
        .level_two    (level_two),
        .block_ready  (block_ready),
        .rect_ready   (rect_ready),
        .blue_paint   (blue_paint),
        .orange_paint (orange_paint),
        .blue_score   (blue_score),
        .orange_score (orange_score)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    typedef enum {M_TITLE, M_REVEAL, M_PLAY, M_HOLD} mode_t;
    mode_t m_mode;
    int    m_lvl;
    int    m_ticks;              // frame ticks seen since entering m_mode
    bit    m_ready[20];
    bit    m_blue[20];
    bit    m_orange[20];

    int n_cmp = 0;
    int n_mis = 0;

    function automatic void m_clear();
        for (int i = 0; i < 20; i++) begin
            m_ready[i] = 0; m_blue[i] = 0; m_orange[i] = 0;
        end
    endfunction

    function automatic void m_reset();
        m_mode = M_TITLE; m_lvl = 0; m_ticks = 0;
        m_clear();
    endfunction

    function automatic void m_tick();
        logic [19:0] mv;
        mv = (m_lvl == 1) ? MASK2 : MASK1;
        case (m_mode)
            M_TITLE:  m_ticks++;
            M_REVEAL: begin
                if (mv[m_ticks]) m_ready[m_ticks] = 1;
                m_ticks++;
                if (m_ticks == 20) begin m_mode = M_PLAY; m_ticks = 0; end
            end
            M_HOLD: begin
                m_ticks++;
                if (m_ticks == HOLD_N) begin
                    m_clear();
                    m_ticks = 0;
                    if (m_lvl == 0) begin m_lvl = 1; m_mode = M_REVEAL; end
                    else m_mode = M_TITLE;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void m_start();
        if (m_mode == M_TITLE) begin
            m_mode = M_REVEAL; m_lvl = 0; m_ticks = 0; m_clear();
        end else if (m_mode == M_PLAY) begin
            m_mode = M_TITLE; m_ticks = 0; m_clear();
        end
    endfunction

    function automatic void m_hit(input bit bv, input int bi, input bit ov, input int oi);
        bit done;
        if (m_mode != M_PLAY) return;
        if (!(bv && ov && bi == oi)) begin
            if (bv && bi < 20 && m_ready[bi]) begin m_blue[bi] = 1; m_orange[bi] = 0; end
            if (ov && oi < 20 && m_ready[oi]) begin m_orange[oi] = 1; m_blue[oi] = 0; end
        end
        done = 1;
        for (int i = 0; i < 20; i++)
            if (m_ready[i] && !(m_blue[i] || m_orange[i])) done = 0;
        if (done) begin m_mode = M_HOLD; m_ticks = 0; end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [19:0] er, eb, eo, gr, gb, go;
        int          sb, so;
        bit          in_title;
        sb = 0; so = 0;
        for (int i = 0; i < 20; i++) begin
            er[i] = m_ready[i]; eb[i] = m_blue[i]; eo[i] = m_orange[i];
            sb += int'(m_blue[i]); so += int'(m_orange[i]);
            if (i < 14) gr[i] = block_ready[i];
            else        gr[i] = rect_ready[i - 14];
            gb[i] = blue_paint[i]; go[i] = orange_paint[i];
        end
`ifndef SCORE_EN
        sb = 0; so = 0;
`endif
        in_title = (m_mode == M_TITLE);
        check({tag, "/title"},     32'(title),     32'(in_title));
        check({tag, "/pstart"},    32'(pstart),    32'(in_title && ((m_ticks / BLINK) % 2 == 0)));
        check({tag, "/level_one"}, 32'(level_one), 32'(!in_title && m_lvl == 0));
        check({tag, "/level_two"}, 32'(level_two), 32'(!in_title && m_lvl == 1));
        check({tag, "/ready"},     32'(gr), 32'(er));
        check({tag, "/blue"},      32'(gb), 32'(eb));
        check({tag, "/orange"},    32'(go), 32'(eo));
        check({tag, "/bscore"},    32'(blue_score),   32'(sb));
        check({tag, "/oscore"},    32'(orange_score), 32'(so));
    endtask

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_tick();
        frame_clk = 1'b1;
        repeat (4) step();
        frame_clk = 1'b0;
        repeat (4) step();
        m_tick();
    endtask

    task automatic do_start();
        start_key = 1'b1;
        step();
        start_key = 1'b0;
        repeat (2) step();
        m_start();
    endtask

    // start_edge and frame_tick land on the same Clk; start must win.
    task automatic do_start_with_tick();
        frame_clk = 1'b1;
        repeat (2) step();
        start_key = 1'b1;
        step();
        start_key = 1'b0;
        repeat (3) step();
        frame_clk = 1'b0;
        repeat (4) step();
        m_start();
    endtask

    task automatic do_hit(input bit bv, input int bi, input bit ov, input int oi);
        hit_if.blue_hit_valid   = bv;
        hit_if.blue_hit_idx     = 5'(bi);
        hit_if.orange_hit_valid = ov;
        hit_if.orange_hit_idx   = 5'(oi);
        step();
        hit_if.blue_hit_valid   = 1'b0;
        hit_if.orange_hit_valid = 1'b0;
        repeat (2) step();
        m_hit(bv, bi, ov, oi);
    endtask

    task automatic rand_hit(input int avoid);
        int bi, oi;
        bit bv, ov;
        bi = int'($urandom_range(0, 31)); if (bi == avoid) bi = avoid + 1;
        oi = int'($urandom_range(0, 31)); if (oi == avoid) oi = avoid + 1;
        if ($urandom_range(0, 3) == 0) oi = bi;
        bv = 1'($urandom_range(0, 1));
        ov = 1'($urandom_range(0, 1));
        do_hit(bv, bi, ov, oi);
    endtask

    task automatic reveal_all(input string tag);
        for (int t = 0; t < 20; t++) begin
            rand_hit(-1);        // hits during reveal must be ignored
            do_tick();
            check_all($sformatf("%s_t%0d", tag, t + 1));
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l1_list[10];
        l1_list = '{0, 1, 2, 3, 4, 5, 6, 14, 15, 16};

        Reset = 1'b1; frame_clk = 1'b0; start_key = 1'b0;
        hit_if.blue_hit_valid = 1'b0; hit_if.blue_hit_idx = '0;
        hit_if.orange_hit_valid = 1'b0; hit_if.orange_hit_idx = '0;
        m_reset();
        repeat (2) step();
        check_all("reset");
        Reset = 1'b0;
        step();
        check_all("post_reset");

        // Title screen blink: toggles at tick 30 and 60.
        for (int t = 1; t <= 60; t++) begin
            do_tick();
            check_all($sformatf("title_t%0d", t));
        end

        // Level one reveal, entered with a coincident frame tick.
        do_start_with_tick();
        check_all("start_l1");
        reveal_all("reveal_l1");

        // Directed paint rules.
        do_hit(1, 3, 1, 3);  check_all("same_idx");
        do_hit(1, 3, 0, 0);  check_all("blue3");
        do_hit(0, 0, 1, 3);  check_all("orange3");
        do_hit(1, 10, 0, 0); check_all("not_ready");
        do_hit(0, 0, 1, 25); check_all("out_of_range");
        do_hit(1, 0, 1, 1);  check_all("both_diff");

        // Random hits that can never finish the level (target 16 avoided).
        for (int k = 0; k < 30; k++) begin
            rand_hit(16);
            check_all($sformatf("rand_l1_%0d", k));
        end

        // Finish level one: 4 blue then 6 orange.
        for (int k = 0; k < 10; k++) begin
            if (k < 4) do_hit(1, l1_list[k], 0, 0);
            else       do_hit(0, 0, 1, l1_list[k]);
            check_all($sformatf("fill_l1_%0d", k));
        end
`ifdef SCORE_EN
        check("score_blue4",   32'(blue_score),   32'd4);
        check("score_orange6", 32'(orange_score), 32'd6);
`else
        check("score_blue_off",   32'(blue_score),   32'd0);
        check("score_orange_off", 32'(orange_score), 32'd0);
`endif
        do_hit(1, 4, 0, 0); check_all("hold_frozen");

        for (int t = 1; t <= HOLD_N; t++) begin
            do_tick();
            check_all($sformatf("hold_l1_t%0d", t));
        end

        reveal_all("reveal_l2");
        for (int k = 0; k < 40; k++) begin
            rand_hit(19);
            check_all($sformatf("rand_l2_%0d", k));
        end
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) do_hit(1, i, 0, 0);
            else            do_hit(0, 0, 1, i);
            check_all($sformatf("fill_l2_%0d", i));
        end
        for (int t = 1; t <= HOLD_N; t++) begin
            do_tick();
            check_all($sformatf("hold_l2_t%0d", t));
        end

        // Abort from PLAY with the start key.
        do_start();
        reveal_all("reveal_ab");
        do_hit(1, 2, 0, 0); check_all("abort_paint");
        do_start();         check_all("abort");

        // Asynchronous reset mid-PLAY with paint set.
        do_start();
        reveal_all("reveal_rs");
        do_hit(1, 5, 1, 6); check_all("pre_reset");
        Reset = 1'b1;
        #1;
        m_reset();
        check_all("async_reset");
        step();
        check_all("reset_held");
        Reset = 1'b0;
        step();
        check_all("reset_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
